med_window: RTL

Upstream feeder for the median core. It accepts a raster-scan pixel stream and keeps two line buffers plus a 3x3 window. For every interior pixel it serialises the 9-pixel neighbourhood into the median core on DI/DSI, then holds off the input stream until the core signals completion. It sits between the pixel source and the median wrapper (MED plus its sequencer) in the filter datapath.

---
 rtl/med_window_pkg.sv | 17 +
 rtl/med_window_if.sv | 22 ++
 rtl/med_window_line_buf.sv | 23 ++
 rtl/med_window.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/med_window_pkg.sv
// Shared types and constants for the median-window feeder and the median core.
package med_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        WAIT = 2'd2
    } state_e;

    localparam int NB_PIXEL = 9;
    localparam int IDX_W    = 4;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/med_window_if.sv
// Pixel-stream and median-core handshake bundle of the window feeder.
interface med_window_if #(
    parameter int SIZE = 8
) ();
    logic [SIZE-1:0] pix_in;
    logic            pix_valid;
    logic            pix_ready;
    logic [SIZE-1:0] di;
    logic            dsi;
    logic            med_done;
    logic            frame_done;

    modport slave (
        input  pix_in, pix_valid, med_done,
        output pix_ready, di, dsi, frame_done
    );

    modport master (
        output pix_in, pix_valid, med_done,
        input  pix_ready, di, dsi, frame_done
    );
endinterface

// File: rtl/med_window_line_buf.sv
// One image line of pixels: combinational read, synchronous write, no reset.
module line_buf #(
    parameter int SIZE   = 8,
    parameter int WIDTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [SIZE-1:0]   wdata_i,
    output logic [SIZE-1:0]   rdata_o
);
    logic [SIZE-1:0] mem_q [WIDTH];

    assign rdata_o = mem_q[addr_i];

    // Line storage write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end
endmodule

// File: rtl/med_window.sv
// Raster-scan 3x3 window builder that serialises each interior neighbourhood
// into the median core and stalls the pixel stream until the core is done.
module med_window
    import med_pkg::*;
#(
    parameter int SIZE   = 8,
    parameter int WIDTH  = 64,
    parameter int HEIGHT = 64
) (
    input  logic         clk_i,
    input  logic         rst_i,
    med_window_if.slave  bus
);
    localparam int COL_W = cnt_w(WIDTH);
    localparam int ROW_W = cnt_w(HEIGHT);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [COL_W-1:0]   col_q;
    logic [ROW_W-1:0]   row_q;
    logic               last_q;
    logic               frame_done_q, frame_done_d;
    logic [SIZE-1:0]    win_q   [3][3];
    logic [SIZE-1:0]    burst_q [NB_PIXEL];
    logic [SIZE-1:0]    new_col_s [3];
    logic [SIZE-1:0]    top_rd_s, mid_rd_s;
    logic               accept_s, win_evt_s, col_last_s, row_last_s;

    assign accept_s   = bus.pix_valid & bus.pix_ready;
    assign col_last_s = (col_q == COL_W'(WIDTH - 1));
    assign row_last_s = (row_q == ROW_W'(HEIGHT - 1));
    assign win_evt_s  = (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));

    assign new_col_s[0] = top_rd_s;
    assign new_col_s[1] = mid_rd_s;
    assign new_col_s[2] = bus.pix_in;

    line_buf #(.SIZE(SIZE), .WIDTH(WIDTH), .ADDR_W(COL_W)) u_lb_top (
        .clk_i   (clk_i),
        .we_i    (accept_s),
        .addr_i  (col_q),
        .wdata_i (mid_rd_s),
        .rdata_o (top_rd_s)
    );

    line_buf #(.SIZE(SIZE), .WIDTH(WIDTH), .ADDR_W(COL_W)) u_lb_mid (
        .clk_i   (clk_i),
        .we_i    (accept_s),
        .addr_i  (col_q),
        .wdata_i (bus.pix_in),
        .rdata_o (mid_rd_s)
    );

    // Raster position of the pixel being accepted
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept_s) begin
            if (col_last_s) begin
                col_q <= '0;
                row_q <= row_last_s ? '0 : row_q + ROW_W'(1);
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    // Window shift and burst capture; the burst takes the post-shift window
    always_ff @(posedge clk_i) begin
        if (accept_s) begin
            for (int r = 0; r < 3; r++) begin
                win_q[r][0] <= win_q[r][1];
                win_q[r][1] <= win_q[r][2];
                win_q[r][2] <= new_col_s[r];
                if (win_evt_s) begin
                    burst_q[3*r]     <= win_q[r][1];
                    burst_q[3*r + 1] <= win_q[r][2];
                    burst_q[3*r + 2] <= new_col_s[r];
                end
            end
        end
    end

    // FSM state, burst index, last-window flag and frame-done pulse
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            last_q       <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            frame_done_q <= frame_done_d;
            if (accept_s && win_evt_s) begin
                last_q <= col_last_s && row_last_s;
            end
        end
    end

    // Next-state logic
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept_s && win_evt_s) begin
                    state_d = SEND;
                    idx_d   = '0;
                end else begin
                    state_d = IDLE;
                end
            end
            SEND: begin
                if (idx_q == IDX_W'(NB_PIXEL - 1)) begin
                    state_d = WAIT;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            WAIT: begin
                if (bus.med_done) begin
                    state_d      = IDLE;
                    frame_done_d = last_q;
                end else begin
                    state_d = WAIT;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    // Ready is masked by reset so nothing is accepted in a reset cycle
    assign bus.pix_ready  = (state_q == IDLE) && !rst_i;
    assign bus.dsi        = (state_q == SEND);
    assign bus.di         = (state_q == SEND) ? burst_q[idx_q] : '0;
    assign bus.frame_done = frame_done_q;
endmodule
